// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception sequencer.
package exc_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH_EXC = 2'd1,
    HANDLER   = 2'd2,
    FLUSH_RET = 2'd3
  } exc_state_t;

  // Exception syndrome codes reported on ESR.
  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_IRQ    = 4'b0001;
  localparam logic [3:0] ESR_INVOP  = 4'b0010;
  localparam logic [3:0] ESR_DFAULT = 4'b1111;

  // Default handler entry address.
  localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'h00000000000000D8;

endpackage

// File: rtl/exc_controller_if.sv
// Commit-point / PC-select interface of the exception sequencer.
// slave: the sequencer; master: the commit stage and PC mux side.
interface exc_controller_if #(
  parameter int N = 64
);
  logic         CommitValid;
  logic [N-1:0] CommitPC;
  logic         InvOp;
  logic         ERet;
  logic         ExtIRQ;
  logic         ExtIAck;
  logic         PcRedirect;
  logic [N-1:0] PcTarget;
  logic         Flush;
  logic [N-1:0] ELR;
  logic [3:0]   ESR;
  logic         InHandler;

  modport slave (
    input  CommitValid, CommitPC, InvOp, ERet, ExtIRQ,
    output ExtIAck, PcRedirect, PcTarget, Flush, ELR, ESR, InHandler
  );

  modport master (
    output CommitValid, CommitPC, InvOp, ERet, ExtIRQ,
    input  ExtIAck, PcRedirect, PcTarget, Flush, ELR, ESR, InHandler
  );
endinterface

// File: rtl/exc_controller_flush_timer.sv
// Loadable down-counter: holds flush high for FLUSH_CYCLES cycles after a
// load and flags the last flush cycle with done.
module flush_timer #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic flush,
  output logic done
);
  logic [3:0] cnt;

  // done marks the final cycle of the flush window.
  assign done = flush && (cnt == 4'd0);

  // Count register: load starts a new window, otherwise count down to zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    if (reset) begin
      cnt   <= 4'd0;
      flush <= 1'b0;
    end else if (load) begin
      cnt   <= 4'(FLUSH_CYCLES - 1);
      flush <= 1'b1;
    end else if (done) begin
      flush <= 1'b0;
    end else if (flush) begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/exc_controller.sv
// Exception sequencer: captures ELR/ESR at the commit point, redirects the
// PC to the handler or back to ELR, and holds a fixed-length pipeline flush.
// Optional: define EXC_STATS_EN to add the saturating ExcCount output.
module exc_controller
  import exc_pkg::*;
#(
  parameter int           N            = 64,
  parameter logic [N-1:0] EXC_VECTOR   = N'(EXC_VECTOR_DEFAULT),
  parameter int           FLUSH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  exc_controller_if.slave  bus
`ifdef EXC_STATS_EN
  ,
  output logic [15:0]      ExcCount
`endif
);
  exc_state_t   state, state_next;
  logic         timer_load, timer_done;
  logic         redirect_next, iack_next, inh_next, exc_entry;
  logic [N-1:0] target_next, elr_next;
  logic [3:0]   esr_next;

  flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .flush (bus.Flush),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and next-output decode from the commit-point events.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next    = state;
    timer_load    = 1'b0;
    redirect_next = 1'b0;
    iack_next     = 1'b0;
    exc_entry     = 1'b0;
    inh_next      = bus.InHandler;
    target_next   = bus.PcTarget;
    elr_next      = bus.ELR;
    esr_next      = bus.ESR;

    unique case (state)
      IDLE: begin
        if (bus.CommitValid && (bus.InvOp || bus.ExtIRQ)) begin
          state_next    = FLUSH_EXC;
          timer_load    = 1'b1;
          redirect_next = 1'b1;
          exc_entry     = 1'b1;
          target_next   = EXC_VECTOR;
          if (bus.InvOp) begin
            elr_next = bus.CommitPC;
            esr_next = ESR_INVOP;
          end else begin
            // The interrupted instruction completes; resume after it.
            elr_next = bus.CommitPC + N'(4);
            esr_next = ESR_IRQ;
          end
        end
      end

      FLUSH_EXC: begin
        if (timer_done) begin
          state_next = HANDLER;
          inh_next   = 1'b1;
          iack_next  = (bus.ESR == ESR_IRQ);
        end
      end

      HANDLER: begin
        if (bus.CommitValid && bus.InvOp) begin
          // Double fault: keep the original ELR so the return still works.
          state_next    = FLUSH_EXC;
          timer_load    = 1'b1;
          redirect_next = 1'b1;
          exc_entry     = 1'b1;
          target_next   = EXC_VECTOR;
          esr_next      = ESR_DFAULT;
        end else if (bus.CommitValid && bus.ERet) begin
          state_next    = FLUSH_RET;
          timer_load    = 1'b1;
          redirect_next = 1'b1;
          target_next   = bus.ELR;
          inh_next      = 1'b0;
        end
      end

      FLUSH_RET: begin
        if (timer_done) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Registered outputs and the ELR/ESR architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.PcRedirect <= 1'b0;
      bus.PcTarget   <= '0;
      bus.ExtIAck    <= 1'b0;
      bus.InHandler  <= 1'b0;
      bus.ELR        <= '0;
      bus.ESR        <= ESR_NONE;
    end else begin
      bus.PcRedirect <= redirect_next;
      bus.PcTarget   <= target_next;
      bus.ExtIAck    <= iack_next;
      bus.InHandler  <= inh_next;
      bus.ELR        <= elr_next;
      bus.ESR        <= esr_next;
    end
  end

`ifdef EXC_STATS_EN
  // Saturating count of exception entries, double faults included.
  always_ff @(posedge clk) begin
    if (reset)                              ExcCount <= 16'd0;
    else if (exc_entry && ExcCount != 16'hFFFF) ExcCount <= ExcCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_exc_controller.sv
// Self-checking bench for exc_controller: every redirect is matched against
// a queue of expected (target, ELR, ESR) entries pushed with the stimulus.
module tb_exc_controller;
  localparam int N = 64;
  localparam int FC = 3;
  localparam logic [63:0] VEC = 64'hD8;

  typedef struct {
    logic [63:0] target;
    logic [63:0] elr;
    logic [3:0]  esr;
  } redir_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;
  redir_t exp_q[$];
`ifdef EXC_STATS_EN
  logic [15:0] ExcCount;
`endif

  exc_controller_if #(.N(N)) bus ();

  exc_controller #(.N(N), .EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef EXC_STATS_EN
    ,
    .ExcCount (ExcCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CommitValid = 1'b0;
    bus.CommitPC    = '0;
    bus.InvOp       = 1'b0;
    bus.ERet        = 1'b0;
    bus.ExtIRQ      = 1'b0;
  endtask

  // One committing instruction for a single cycle.
  task automatic commit(input logic [63:0] pc, input logic inv, input logic eret,
                        input logic irq);
    bus.CommitValid = 1'b1;
    bus.CommitPC    = pc;
    bus.InvOp       = inv;
    bus.ERet        = eret;
    bus.ExtIRQ      = irq;
    step();
    idle_inputs();
  endtask

  // Called right after the redirecting edge: counts Flush cycles, then
  // checks the handler-entry state on the first cycle after the window.
  task automatic flush_then(input string tag, input logic inh, input logic iack);
    int n = 0;
    while (bus.Flush && n < 20) begin
      n++;
      step();
    end
    check({tag, "_flush_len"}, 64'(n), 64'(FC));
    check({tag, "_inhandler"}, 64'(bus.InHandler), 64'(inh));
    check({tag, "_iack"}, 64'(bus.ExtIAck), 64'(iack));
    step();
    check({tag, "_iack_off"}, 64'(bus.ExtIAck), 64'd0);
  endtask

  task automatic push(input logic [63:0] t, input logic [63:0] e, input logic [3:0] s);
    redir_t r;
    r.target = t;
    r.elr    = e;
    r.esr    = s;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: each redirect pulse consumes one expected entry.
  always @(negedge clk) begin
    if (!reset && bus.PcRedirect) begin
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", 64'd1, 64'd0);
      end else begin
        redir_t r;
        r = exp_q.pop_front();
        check("redir_target", bus.PcTarget, r.target);
        check("redir_elr", bus.ELR, r.elr);
        check("redir_esr", 64'(bus.ESR), 64'(r.esr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();
    check("rst_redirect", 64'(bus.PcRedirect), 64'd0);
    check("rst_target", bus.PcTarget, 64'd0);
    check("rst_flush", 64'(bus.Flush), 64'd0);
    check("rst_elr", bus.ELR, 64'd0);
    check("rst_esr", 64'(bus.ESR), 64'd0);
    check("rst_inh", 64'(bus.InHandler), 64'd0);
    check("rst_iack", 64'(bus.ExtIAck), 64'd0);

    // Undefined opcode at 0x40, then return.
    push(VEC, 64'h40, 4'b0010);
    commit(64'h40, 1'b1, 1'b0, 1'b0);
    check("inv_redirect", 64'(bus.PcRedirect), 64'd1);
    flush_then("inv", 1'b1, 1'b0);
    push(64'h40, 64'h40, 4'b0010);
    commit(64'h80, 1'b0, 1'b1, 1'b0);
    check("ret_inh_drop", 64'(bus.InHandler), 64'd0);
    flush_then("ret1", 1'b0, 1'b0);

    // External IRQ at 0x100; masked IRQ inside the handler; return.
    push(VEC, 64'h104, 4'b0001);
    commit(64'h100, 1'b0, 1'b0, 1'b1);
    flush_then("irq", 1'b1, 1'b1);
    commit(64'hD8, 1'b0, 1'b0, 1'b1);
    check("mask_redirect", 64'(bus.PcRedirect), 64'd0);
    check("mask_flush", 64'(bus.Flush), 64'd0);
    check("mask_inh", 64'(bus.InHandler), 64'd1);
    push(64'h104, 64'h104, 4'b0001);
    commit(64'hDC, 1'b0, 1'b1, 1'b0);
    flush_then("ret2", 1'b0, 1'b0);

    // InvOp and IRQ together, then a double fault, then return.
    do_reset();
    push(VEC, 64'h20, 4'b0010);
    commit(64'h20, 1'b1, 1'b0, 1'b1);
    flush_then("both", 1'b1, 1'b0);
    push(VEC, 64'h20, 4'b1111);
    commit(64'hD8, 1'b1, 1'b1, 1'b0);
    check("df_redirect", 64'(bus.PcRedirect), 64'd1);
    flush_then("df", 1'b1, 1'b0);
`ifdef EXC_STATS_EN
    check("exc_count", 64'(ExcCount), 64'd2);
`endif
    push(64'h20, 64'h20, 4'b1111);
    commit(64'hE0, 1'b0, 1'b1, 1'b0);
    flush_then("ret3", 1'b0, 1'b0);

    // ERet in IDLE is ignored and PcTarget holds.
    commit(64'h300, 1'b0, 1'b1, 1'b0);
    check("idle_eret_redirect", 64'(bus.PcRedirect), 64'd0);
    check("idle_eret_flush", 64'(bus.Flush), 64'd0);
    check("target_hold", bus.PcTarget, 64'h20);

    // Reset during the second Flush cycle aborts the sequence.
    push(VEC, 64'h60, 4'b0010);
    commit(64'h60, 1'b1, 1'b0, 1'b0);
    step();
    check("abort_flush_pre", 64'(bus.Flush), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_flush", 64'(bus.Flush), 64'd0);
    check("abort_target", bus.PcTarget, 64'd0);
    check("abort_elr", bus.ELR, 64'd0);
    check("abort_esr", 64'(bus.ESR), 64'd0);
    check("abort_inh", 64'(bus.InHandler), 64'd0);
`ifdef EXC_STATS_EN
    check("abort_count", 64'(ExcCount), 64'd0);
`endif

    // IRQ at the top of the address space: ELR wraps to zero.
    push(VEC, 64'h0, 4'b0001);
    commit(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1);
    flush_then("wrap", 1'b1, 1'b1);
    push(64'h0, 64'h0, 4'b0001);
    commit(64'hD8, 1'b0, 1'b1, 1'b0);
    flush_then("ret4", 1'b0, 1'b0);

    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
